// File: rtl/scan_sequencer_3b_pkg.sv
// scan_sequencer_3b_pkg: shared code widths and FSM state encoding
package scan_sequencer_3b_pkg;
   localparam int CODE_W    = 3;
   localparam int NUM_CODES = 8;
   typedef enum logic [1:0] {IDLE, RUN, SWEEP} state_t;
endpackage

// File: rtl/scan_sequencer_3b_dwell_timer.sv
// scan_sequencer_3b_dwell_timer: dwell counter with terminal count at div_q
module scan_sequencer_3b_dwell_timer #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tc
);
   logic [DIV_W-1:0] r_cnt;
   assign o_tc = r_cnt == i_div;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en) r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/scan_sequencer_3b.sv
// scan_sequencer_3b: registered 3-bit scan code generator with programmable dwell
module scan_sequencer_3b
   import scan_sequencer_3b_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode,
   input  logic              start,
   input  logic              stop,
   input  logic              dir,
   input  logic              load,
   input  logic [CODE_W-1:0] load_val,
   input  logic [DIV_W-1:0]  div,
   output logic              A,
   output logic              B,
   output logic              C,
   output logic              busy,
   output logic              step,
   output logic              wrap,
   output logic              done
);
   state_t            r_state, w_state_nxt;
   logic [CODE_W-1:0] r_code, w_code_nxt;
   logic [2:0]        r_sweep, w_sweep_nxt;
   logic [DIV_W-1:0]  r_div, w_div_nxt;
   logic              r_dir, w_dir_nxt;
   logic              w_tc, w_busy, w_last, w_adv;

   assign w_busy = r_state != IDLE;
   assign w_last = r_state == SWEEP && r_sweep == 3'(NUM_CODES - 1);
   assign w_adv  = w_busy && w_tc && !stop && !w_last;
   assign {A, B, C} = r_code;
   assign busy = w_busy;

   // Timer is held clear whenever idle or aborting, so every start begins a fresh dwell
   scan_sequencer_3b_dwell_timer #(.DIV_W(DIV_W)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (!w_busy || stop),
      .i_en  (w_busy),
      .i_div (r_div),
      .o_tc  (w_tc)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_code;
      w_sweep_nxt = r_sweep;
      w_div_nxt   = r_div;
      w_dir_nxt   = r_dir;
      step        = w_adv;
      wrap        = w_adv && r_code == (r_dir ? 3'd0 : 3'd7);
      done        = w_last && w_tc && !stop;
      if (r_state == IDLE) begin
         w_sweep_nxt = '0;
         if (load) w_code_nxt = load_val;
         if (start && !stop) begin
            w_state_nxt = mode ? SWEEP : RUN;
            w_dir_nxt   = dir;
            w_div_nxt   = div;
         end
      end else if (stop || done) w_state_nxt = IDLE;
      else if (w_adv) begin
         w_code_nxt  = r_dir ? r_code - 1'b1 : r_code + 1'b1;
         w_sweep_nxt = r_sweep + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= IDLE;
         r_code  <= '0;
         r_sweep <= '0;
         r_div   <= '0;
         r_dir   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_code  <= w_code_nxt;
         r_sweep <= w_sweep_nxt;
         r_div   <= w_div_nxt;
         r_dir   <= w_dir_nxt;
      end
endmodule

// File: tb/tb_scan_sequencer_3b.sv
// tb_scan_sequencer_3b: model-checked directed bench for scan_sequencer_3b
module tb_scan_sequencer_3b;
   logic       clk = 0, rst_n = 0, mode = 0, start = 0, stop = 0, dir = 0, load = 0;
   logic [2:0] load_val = 0;
   logic [7:0] div = 0;
   logic       A, B, C, busy, step, wrap, done;
   int         total = 0, bad = 0;
   int         n_busy = 0, n_wrap = 0, n_done = 0, n_step = 0;
   bit         m_busy = 0, m_sweep = 0, m_dir = 0;
   int         m_n = 0, m_d = 0;
   logic [2:0] m_code = 0, m_c0 = 0;

   scan_sequencer_3b #(.DIV_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .stop(stop), .dir(dir),
      .load(load), .load_val(load_val), .div(div), .A(A), .B(B), .C(C),
      .busy(busy), .step(step), .wrap(wrap), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Code during the i-th dwell after start: start code stepped i times, mod 8
   function automatic logic [2:0] m_at(input int i);
      return m_dir ? 3'(m_c0 - 3'(i)) : 3'(m_c0 + 3'(i));
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_busy <= 0;
         m_code <= 0;
         m_n    <= 0;
      end else if (!m_busy) begin
         if (load) m_code <= load_val;
         if (start && !stop) begin
            m_busy  <= 1;
            m_c0    <= load ? load_val : m_code;
            m_n     <= 0;
            m_d     <= int'(div);
            m_dir   <= dir;
            m_sweep <= mode;
         end
      end else if (stop || (m_sweep && m_n == 8 * (m_d + 1) - 1)) begin
         m_busy <= 0;
         m_code <= m_at(m_n / (m_d + 1));
      end else m_n <= m_n + 1;

   always @(negedge clk)
      if (rst_n) begin
         logic [2:0] ec;
         bit last, fin, es, ew, ed;
         ec   = m_busy ? m_at(m_n / (m_d + 1)) : m_code;
         last = (m_n % (m_d + 1)) == m_d;
         fin  = m_sweep && (m_n / (m_d + 1)) == 7;
         es   = m_busy && last && !fin && !stop;
         ew   = es && ec == (m_dir ? 3'd0 : 3'd7);
         ed   = m_busy && last && fin && !stop;
         chk("code", int'({A, B, C}), int'(ec));
         chk("busy", int'(busy), int'(m_busy));
         chk("step", int'(step), int'(es));
         chk("wrap", int'(wrap), int'(ew));
         chk("done", int'(done), int'(ed));
         n_busy += int'(busy);
         n_step += int'(step);
         n_wrap += int'(wrap);
         n_done += int'(done);
      end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_cnt;
      n_busy = 0; n_step = 0; n_wrap = 0; n_done = 0;
   endtask

   task automatic go(input bit m, input bit d, input int dv, input bit ld, input int lv);
      mode = m; dir = d; div = 8'(dv); load = ld; load_val = 3'(lv); start = 1;
      tick();
      start = 0; load = 0;
   endtask

   task automatic wait_idle(input int lim);
      for (int k = 0; k < lim && busy; k++) tick();
      chk("idle_timeout", int'(busy), 0);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_abc"}, int'({A, B, C}), 0);
      chk({nm, "_busy"}, int'(busy), 0);
      chk({nm, "_step"}, int'(step), 0);
      chk({nm, "_wrap"}, int'(wrap), 0);
      chk({nm, "_done"}, int'(done), 0);
   endtask

   initial begin
      #1 chk_zero("por");
      @(posedge clk);
      #1 rst_n = 1;
      tick();
      // single sweep from 3 via simultaneous load+start, div=1
      clr_cnt();
      go(1, 0, 1, 1, 3);
      wait_idle(40);
      chk("sw_busy_cycles", n_busy, 16);
      chk("sw_steps", n_step, 7);
      chk("sw_wraps", n_wrap, 1);
      chk("sw_dones", n_done, 1);
      chk("sw_final", int'({A, B, C}), 2);
      // continuous down from 0, div=0, then stop
      clr_cnt();
      go(0, 1, 0, 1, 0);
      repeat (20) tick();
      chk("run_steps", n_step, 20);
      chk("run_wraps", n_wrap, 3);
      chk("run_dones", n_done, 0);
      stop = 1;
      tick();
      stop = 0;
      chk("run_stop_busy", int'(busy), 0);
      chk("run_stop_code", int'({A, B, C}), 4);
      // stop in 3rd dwell of a sweep, then start+stop while idle
      clr_cnt();
      go(1, 0, 2, 1, 5);
      repeat (7) tick();
      stop = 1;
      tick();
      stop = 0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_code", int'({A, B, C}), 7);
      chk("abort_dones", n_done, 0);
      stop = 1; start = 1;
      tick();
      stop = 0; start = 0;
      chk("start_stop_busy", int'(busy), 0);
      tick();
      chk("start_stop_busy2", int'(busy), 0);
      // sweep down with inputs thrashed while busy
      clr_cnt();
      go(1, 1, 3, 1, 6);
      for (int k = 0; k < 64 && busy; k++) begin
         load = 1'($urandom); load_val = 3'($urandom); dir = 1'($urandom);
         div = 8'($urandom); start = 1'($urandom); mode = 1'($urandom);
         tick();
      end
      load = 0; start = 0; mode = 0; dir = 0; div = 0;
      chk("noisy_idle", int'(busy), 0);
      chk("noisy_busy_cycles", n_busy, 32);
      chk("noisy_final", int'({A, B, C}), 7);
      chk("noisy_dones", n_done, 1);
      // longest dwell
      clr_cnt();
      go(1, 0, 255, 1, 2);
      wait_idle(2100);
      chk("long_busy_cycles", n_busy, 2048);
      chk("long_dones", n_done, 1);
      chk("long_wraps", n_wrap, 1);
      chk("long_final", int'({A, B, C}), 1);
      // asynchronous reset in the middle of a run
      go(0, 0, 0, 1, 5);
      repeat (3) tick();
      chk("pre_rst_busy", int'(busy), 1);
      #2 rst_n = 0;
      #1 chk_zero("async_rst");
      @(posedge clk);
      #1 rst_n = 1;
      tick();
      chk("post_rst_busy", int'(busy), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
